// File: rtl/scene_query_multi_if.sv
// scene_query_multi_if: query, result and object-table signals for scene_query_multi
//   valid_in/ready_out/pos                : query handshake and query point {z,y,x}
//   valid_out/out_ready                   : result handshake
//   closestDistance/closest_id/no_obj     : result payload
//   obj_we/obj_waddr/obj_center/obj_size/obj_type/obj_en : object table write port
interface scene_query_multi_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
);
    logic                  valid_in;
    logic                  ready_out;
    logic [3*DATA_W-1:0]   pos;
    logic                  valid_out;
    logic                  out_ready;
    logic [DATA_W-1:0]     closestDistance;
    logic [ID_W-1:0]       closest_id;
    logic                  no_obj;
    logic                  obj_we;
    logic [ID_W-1:0]       obj_waddr;
    logic [3*DATA_W-1:0]   obj_center;
    logic [DATA_W-1:0]     obj_size;
    logic                  obj_type;
    logic                  obj_en;

    modport master (
        output valid_in, pos, out_ready, obj_we, obj_waddr, obj_center, obj_size, obj_type, obj_en,
        input  ready_out, valid_out, closestDistance, closest_id, no_obj
    );

    modport slave (
        input  valid_in, pos, out_ready, obj_we, obj_waddr, obj_center, obj_size, obj_type, obj_en,
        output ready_out, valid_out, closestDistance, closest_id, no_obj
    );
endinterface

// File: rtl/scene_query_multi.sv
// scene_query_multi: minimum signed distance over a runtime-loaded table of cube/diamond primitives
//   clk, rst : clock, asynchronous active-high reset (clears FSM, outputs and table enables)
//   q        : scene_query_multi_if slave port (query in, result out, table write port)
module scene_query_multi #(
    parameter int                DATA_W    = 32,
    parameter int                FRAC_W    = 24,
    parameter int                NUM_OBJ   = 4,
    parameter int                ID_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    parameter logic [DATA_W-1:0] INV_SQRT3 = 32'h0093CD3A
) (
    input logic              clk,
    input logic              rst,
    scene_query_multi_if.slave q
);
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                    state, state_nxt;
    logic [ID_W-1:0]           idx;
    logic [3*DATA_W-1:0]       pos_q;
    logic signed [DATA_W-1:0]  best;
    logic [ID_W-1:0]           best_id;
    logic                      found;
    logic [DATA_W-1:0]         dist_q;
    logic [ID_W-1:0]           id_q;
    logic                      none_q;

    logic [NUM_OBJ-1:0]        en;
    logic [3*DATA_W-1:0]       ctr  [NUM_OBJ];
    logic [DATA_W-1:0]         size [NUM_OBJ];
    logic [NUM_OBJ-1:0]        typ;

    logic signed [DATA_W-1:0]   ad [3];
    logic signed [DATA_W-1:0]   cube_m, dia_m, s, d_obj, best_nxt;
    logic [DATA_W+1:0]          sum;
    logic signed [2*DATA_W-1:0] prod;
    logic                       hit, last, wr_ok;

    function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a, b);
        logic signed [DATA_W:0] r;
        r = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return (r[DATA_W] != r[DATA_W-1]) ? (r[DATA_W] ? MINV : MAXV) : r[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] a);
        return (a == MINV) ? MAXV : (a[DATA_W-1] ? -a : a);
    endfunction

    assign last  = idx == ID_W'(NUM_OBJ - 1);
    assign wr_ok = state == IDLE && q.obj_we && 32'(q.obj_waddr) < NUM_OBJ;

    // Distance of the entry addressed by idx; all |d| terms are non-negative after saturation
    always_comb begin
        for (int k = 0; k < 3; k++)
            ad[k] = abs_sat(sat_sub(pos_q[k*DATA_W +: DATA_W], ctr[idx][k*DATA_W +: DATA_W]));
        cube_m   = (ad[0] > ad[1]) ? ad[0] : ad[1];
        cube_m   = (ad[2] > cube_m) ? ad[2] : cube_m;
        sum      = {2'b0, ad[0]} + {2'b0, ad[1]} + {2'b0, ad[2]};
        dia_m    = (sum > {2'b0, MAXV}) ? MAXV : sum[DATA_W-1:0];
        s        = sat_sub(typ[idx] ? dia_m : cube_m, size[idx]);
        prod     = $signed({{DATA_W{s[DATA_W-1]}}, s}) * $signed({{DATA_W{1'b0}}, INV_SQRT3});
        d_obj    = typ[idx] ? DATA_W'(prod >>> FRAC_W) : s;
        hit      = en[idx] && (d_obj < best);
        best_nxt = hit ? d_obj : best;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = q.valid_in ? EVAL : IDLE;
            EVAL:    state_nxt = last ? DONE : EVAL;
            DONE:    state_nxt = q.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pos_q   <= '0;
            best    <= MAXV;
            best_id <= '0;
            found   <= 1'b0;
            dist_q  <= '0;
            id_q    <= '0;
            none_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && q.valid_in) begin
                pos_q   <= q.pos;
                idx     <= '0;
                best    <= MAXV;
                best_id <= '0;
                found   <= 1'b0;
            end
            if (state == EVAL) begin
                idx     <= idx + 1'b1;
                best    <= best_nxt;
                best_id <= hit ? idx : best_id;
                found   <= found | hit;
                if (last) begin
                    dist_q <= best_nxt;
                    id_q   <= hit ? idx : best_id;
                    none_q <= ~(found | hit);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            en <= '0;
        else if (wr_ok)
            en[q.obj_waddr] <= q.obj_en;
    end

    // Payload storage needs no reset: entries are ignored until their enable is set
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ctr[q.obj_waddr]  <= q.obj_center;
            size[q.obj_waddr] <= q.obj_size;
            typ[q.obj_waddr]  <= q.obj_type;
        end
    end

    assign q.ready_out       = state == IDLE;
    assign q.valid_out       = state == DONE;
    assign q.closestDistance = dist_q;
    assign q.closest_id      = id_q;
    assign q.no_obj          = none_q;
endmodule
